// File: rtl/alu_issue_ctrl.sv
// Buffers ALU ops in a small FIFO, issues the head to a combinational ALU and
// registers the result into a single output slot drained by valid/ready.
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rega,
    input  logic [31:0]      in_regb,
    output logic [31:0]      alu_instruction,
    output logic [31:0]      alu_regA,
    output logic [31:0]      alu_regB,
    input  logic [31:0]      alu_result,
    input  logic [2:0]       alu_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      rega_mem  [DEPTH];
    logic [31:0]      regb_mem  [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [2:0]       out_flags_q, out_flags_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic empty, full, push, pop;

    // The wrap bit separates full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready = !rst && !full && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (!out_valid_q || out_ready) && !flush;

    assign alu_instruction = empty ? 32'd0 : instr_mem[rd_ptr_q[AW-1:0]];
    assign alu_regA        = empty ? 32'd0 : rega_mem[rd_ptr_q[AW-1:0]];
    assign alu_regB        = empty ? 32'd0 : regb_mem[rd_ptr_q[AW-1:0]];

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign ovf_count  = ovf_count_q;
    assign busy       = !empty || out_valid_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        ovf_count_d  = ovf_count_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + (AW+1)'(1);
                out_valid_d  = 1'b1;
                out_instr_d  = alu_instruction;
                out_result_d = alu_result;
                out_flags_d  = alu_flags;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end

        // Counter survives flush and sticks at its maximum.
        if (pop && alu_flags[0] && (ovf_count_q != {CNT_W{1'b1}})) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            ovf_count_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    // Payload storage needs no reset: entries are only read while valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q[AW-1:0]] <= in_instr;
            rega_mem[wr_ptr_q[AW-1:0]]  <= in_rega;
            regb_mem[wr_ptr_q[AW-1:0]]  <= in_regb;
        end
    end

endmodule
